digit_serial_addsub: RTL and testbench

//   Multi-cycle, parametrised adder/subtractor; successor to the 4-bit ripple-carry adder.

---
 rtl/digit_serial_addsub.sv | 137 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : digit_serial_addsub
//  Purpose  : Multi-cycle add/subtract of two WIDTH-bit operands, DIGIT bits
//             per clock with a registered carry between digits. Valid/ready
//             handshake on both sides; reports sum, carry-out and overflow.
//  Revision : 1.0  initial release
// ============================================================================
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] C_LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   dig_sum;
    logic [DIGIT-1:0] dig;
    logic             dig_c;
    logic             dig_c_msb_in;

    // One DIGIT-wide adder slice; the carry into its top bit is recovered
    // from the sum bit and the two operand bits, which gives the carry into
    // bit WIDTH-1 when the final digit is being processed.
    always_comb begin
        dig_sum      = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};
        dig          = dig_sum[DIGIT-1:0];
        dig_c        = dig_sum[DIGIT];
        dig_c_msb_in = dig[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];
    end

    // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Digits enter at the MSB end so that after NDIG shifts the
                // first digit sits in the least-significant position.
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = dig_c;
                if (cnt_q == C_LAST_DIG) begin
                    cout_d  = dig_c;
                    ovf_d   = dig_c_msb_in ^ dig_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_serial_addsub
//  Purpose  : Self-checking bench for digit_serial_addsub with three
//             configurations: 16/4, 8/8 and 12/1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [11:0] s2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(s0), .cout(cout[0]), .ovf(ovf[0])
    );

    digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(s1), .cout(cout[1]), .ovf(ovf[1])
    );

    digit_serial_addsub #(.WIDTH(12), .DIGIT(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[11:0]), .b(b[11:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(s2), .cout(cout[2]), .ovf(ovf[2])
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs_sum(input logic [1:0] idx);
        case (idx)
            2'd0:    obs_sum = s0;
            2'd1:    obs_sum = {8'h00, s1};
            default: obs_sum = {4'h0, s2};
        endcase
    endfunction

    function automatic int width_of(input logic [1:0] idx);
        case (idx)
            2'd0:    width_of = 16;
            2'd1:    width_of = 8;
            default: width_of = 12;
        endcase
    endfunction

    function automatic int ndig_of(input logic [1:0] idx);
        case (idx)
            2'd0:    ndig_of = 4;
            2'd1:    ndig_of = 1;
            default: ndig_of = 12;
        endcase
    endfunction

    // Reference result {ovf, cout, sum} computed as a whole-word addition.
    function automatic logic [17:0] model(input int w, input logic [15:0] ma,
                                          input logic [15:0] mb, input logic mc,
                                          input logic ms);
        logic [31:0] mask, hmask, aa, bb, c0, full, low;
        logic        co, cmsb;
        mask  = (32'h1 << w) - 32'h1;
        hmask = mask >> 1;
        aa    = {16'h0, ma} & mask;
        bb    = (ms ? ~{16'h0, mb} : {16'h0, mb}) & mask;
        c0    = ms ? 32'h1 : {31'h0, mc};
        full  = aa + bb + c0;
        low   = (aa & hmask) + (bb & hmask) + c0;
        co    = full[w];
        cmsb  = low[w-1];
        model = {cmsb ^ co, co, full[15:0] & mask[15:0]};
    endfunction

    // Run one operation on instance idx and check latency, result and handshake.
    task automatic do_op(input logic [1:0] idx, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo, input bit hold);
        int lat;
        int to;
        to = 0;
        @(negedge clk);
        while (!in_ready[idx] && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (!in_ready[idx]) begin
            chk("accept_timeout", 32'(in_ready[idx]), 32'd1);
            return;
        end
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; sub = ~ts;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid[idx]) break;
        end
        chk("latency", 32'(lat), 32'(ndig_of(idx)));
        chk("sum", 32'(obs_sum(idx)), 32'(es));
        chk("cout", 32'(cout[idx]), 32'(ec));
        chk("ovf", 32'(ovf[idx]), 32'(eo));
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                a = 16'(i * 16'h1111); in_valid[idx] = 1'b1;
                @(negedge clk);
                chk("hold_valid", 32'(out_valid[idx]), 32'd1);
                chk("hold_inrdy", 32'(in_ready[idx]), 32'd0);
                chk("hold_sum", 32'(obs_sum(idx)), 32'(es));
                chk("hold_flags", 32'({ovf[idx], cout[idx]}), 32'({eo, ec}));
            end
            in_valid[idx] = 1'b0;
        end
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        chk("post_valid", 32'(out_valid[idx]), 32'd0);
        chk("post_inrdy", 32'(in_ready[idx]), 32'd1);
        chk("post_sum", 32'(obs_sum(idx)), 32'(es));
    endtask

    task automatic rand_op(input logic [1:0] idx);
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] m;
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        m  = model(width_of(idx), ra, rb, rc, rs);
        do_op(idx, ra, rb, rc, rs, m[15:0], m[16], m[17], 1'b0);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid = '0; out_ready = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_inrdy", 32'(in_ready), 32'h7);
        chk("rst_outvalid", 32'(out_valid), 32'h0);
        chk("rst_sum", 32'({s0, s1, s2}), 32'h0);
        chk("rst_flags", 32'({cout, ovf}), 32'h0);

        // Directed vectors, 16-bit / 4-bit digits.
        do_op(2'd0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        do_op(2'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op(2'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(2'd0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(2'd0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_op(2'd0, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0);
        do_op(2'd0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0);
        do_op(2'd0, 16'hA5A5, 16'h1111, 1'b0, 1'b0, 16'hB6B6, 1'b0, 1'b0, 1'b1);

        // Reset asserted during the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_inrdy", 32'(in_ready[0]), 32'd1);
        chk("abort_outvalid", 32'(out_valid[0]), 32'd0);
        chk("abort_sum", 32'(s0), 32'd0);
        do_op(2'd0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Single-digit and bit-serial configurations.
        do_op(2'd1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0);
        do_op(2'd1, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b1);
        do_op(2'd2, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(2'd2, 16'h0800, 16'h0001, 1'b0, 1'b1, 16'h07FF, 1'b1, 1'b1, 1'b0);

        // Randomised back-to-back operations against the word-level model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                rand_op(2'(k));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
